router_input_buffer: RTL and testbench
======================================

# router_input_buffer

Router input-port stage sitting directly downstream of the per-link direct interconnect: it captures flits arriving on the link, buffers them in a small FIFO, and arbitrates packet framing toward the switch. For each packet it raises a route request from the head flit's destination field, forwards flits once granted, and returns one credit upstream per flit leaving the buffer. Credit-based flow control means the upstream sender never needs a ready signal.

## Interface
- FLIT_W, 32, flit payload width
- DEPTH, 4, FIFO entries; power of two, ≥2; also the upstream initial credit count
- DEST_W, 4, destination field width
- DEST_LSB, 0, LSB position of destination field inside a head flit payload
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  flit present on link this cycle
- in_flit  in  FLIT_W  flit payload
- in_type  in  2  00 body, 01 head, 10 tail, 11 head+tail (single-flit packet)
- credit_out  out  1  one-cycle pulse per flit removed from FIFO
- route_req  out  1  request switch allocation for packet at FIFO front
- route_dest  out  DEST_W  destination of requesting packet
- route_gnt  in  1  allocation granted (sampled only while route_req=1)
- out_valid  out  1  flit available to switch
- out_flit  out  FLIT_W  front flit payload
- out_type  out  2  front flit type
- out_ready  in  1  switch accepts flit
- occupancy  out  clog2(DEPTH+1)  current entry count
- overflow_err  out  1  sticky: write attempted while full
- framing_err  out  1  sticky: non-head flit at front in IDLE

## Operation
- FIFO push when in_valid and (not full, or pop in same cycle); otherwise flit dropped, overflow_err set.
- FSM states IDLE, ROUTE, ACTIVE; reset → IDLE.
- IDLE: if FIFO non-empty and front type is head or head+tail → ROUTE. If front is body or tail → pop it (discard), set framing_err, pulse credit, stay IDLE.
- ROUTE: route_req=1, route_dest=front payload[DEST_LSB +: DEST_W]; on route_gnt → ACTIVE. No pop in ROUTE.
- ACTIVE: out_valid = FIFO non-empty; pop on out_valid & out_ready. Popping tail or head+tail → IDLE; else stay ACTIVE. Head-type flit arriving at front mid-packet is forwarded as-is (no check).
- route_req, out_valid, route_dest, out_flit, out_type combinational from state and FIFO front; out_flit/out_type always show front entry (don't-care when empty).
- credit_out: registered, asserted cycle after every pop (forwarded or discarded).
- Sticky errors clear only on reset.
- Reset mid-packet: FIFO emptied, state IDLE, all outputs 0; no credits issued for discarded contents (upstream resets together).

## Timing
- Reset values: credit_out, route_req, out_valid, occupancy, overflow_err, framing_err = 0; route_dest, out_flit, out_type = 0 (empty FIFO reads entry 0, zeroed at reset).
- Push at edge t → flit at front, occupancy updated, from t+1.
- Head written at t (empty FIFO, IDLE): IDLE→ROUTE at edge t+1... route_req high during cycle t+2; gnt in cycle t+2 → out_valid during t+3.
- Pop at edge t → credit_out high in cycle t+1, exactly one cycle.
- Full + push + pop same cycle: both succeed, occupancy unchanged, no error.
- Pointers wrap modulo DEPTH; occupancy saturates at DEPTH by construction.
- Back-to-back packets: tail pop returns to IDLE; next head needs one IDLE cycle before ROUTE.

## Structure
- Package router_pkg: flit type codes (FLIT_BODY, FLIT_HEAD, FLIT_TAIL, FLIT_SINGLE), FSM state enum, credit width helper.
- Sub-module router_flit_fifo: storage, read/write pointers, count, full/empty; parent holds FSM, credit register, error flags.

## Test plan
- Single packet head(dest=5)/body/tail, gnt one cycle after req, out_ready=1 → route_dest=5, three flits out in order, three credit pulses, end in IDLE, occupancy 0.
- Head+tail single flit, gnt delayed 3 cycles → route_req held 3 cycles, one flit out, one credit, back to IDLE.
- Fill DEPTH=4 with out_ready=0, send 5th flit → occupancy 4, overflow_err=1, 5th flit absent at output.
- Full FIFO, push and pop same cycle → no error, occupancy stays 4, ordering preserved.
- Body flit as first flit after reset → framing_err=1, flit discarded, one credit pulse, route_req never asserted.
- Assert rst_n low mid-packet with 3 entries → all outputs 0 asynchronously, next head after release processed normally.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and helpers for the router input-port stage.
package router_pkg;

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRoute,
    StActive
  } rib_state_e;

  // Width needed to count 0..depth, i.e. entries or outstanding credits.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bit 0 of the type code marks a packet start, bit 1 a packet end.
  function automatic logic is_head(input logic [1:0] flit_type);
    return flit_type[0];
  endfunction

  function automatic logic is_tail(input logic [1:0] flit_type);
    return flit_type[1];
  endfunction

endpackage

// File: rtl/router_flit_fifo.sv
// Flit FIFO storing payload and type; entries are zeroed at reset so the
// front reads as zero while empty.
module router_flit_fifo
  import router_pkg::*;
#(
  parameter int unsigned FLIT_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [FLIT_W-1:0]                push_flit,
  input  logic [1:0]                       push_type,
  input  logic                             pop,
  output logic [FLIT_W-1:0]                front_flit,
  output logic [1:0]                       front_type,
  output logic [credit_width(DEPTH)-1:0]   count,
  output logic                             full,
  output logic                             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = credit_width(DEPTH);

  logic [FLIT_W+1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {push_type, push_flit};
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign {front_type, front_flit} = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/router_input_buffer.sv
// Router input port: buffers link flits, requests a route per packet head,
// forwards the packet once granted and returns one credit per popped flit.
module router_input_buffer
  import router_pkg::*;
#(
  parameter int unsigned FLIT_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DEST_W   = 4,
  parameter int unsigned DEST_LSB = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [FLIT_W-1:0]              in_flit,
  input  logic [1:0]                     in_type,
  output logic                           credit_out,
  output logic                           route_req,
  output logic [DEST_W-1:0]              route_dest,
  input  logic                           route_gnt,
  output logic                           out_valid,
  output logic [FLIT_W-1:0]              out_flit,
  output logic [1:0]                     out_type,
  input  logic                           out_ready,
  output logic [credit_width(DEPTH)-1:0] occupancy,
  output logic                           overflow_err,
  output logic                           framing_err
);

  rib_state_e        state_q, state_d;
  logic              push, pop, full, empty;
  logic              framing_set;
  logic [FLIT_W-1:0] front_flit;
  logic [1:0]        front_type;
  logic              credit_q, overflow_q, framing_q;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = in_valid & (~full | pop);

  router_flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_flit  (in_flit),
    .push_type  (in_type),
    .pop        (pop),
    .front_flit (front_flit),
    .front_type (front_type),
    .count      (occupancy),
    .full       (full),
    .empty      (empty)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    route_req   = 1'b0;
    out_valid   = 1'b0;
    framing_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          if (is_head(front_type)) begin
            state_d = StRoute;
          end else begin
            // Stray body/tail with no open packet: discard and flag it.
            pop         = 1'b1;
            framing_set = 1'b1;
          end
        end
      end
      StRoute: begin
        route_req = 1'b1;
        if (route_gnt) begin
          state_d = StActive;
        end
      end
      StActive: begin
        out_valid = ~empty;
        if (out_valid && out_ready) begin
          pop = 1'b1;
          if (is_tail(front_type)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
      framing_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= pop;
      if (in_valid && full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (framing_set) begin
        framing_q <= 1'b1;
      end
    end
  end

  assign route_dest   = front_flit[DEST_LSB +: DEST_W];
  assign out_flit     = front_flit;
  assign out_type     = front_type;
  assign credit_out   = credit_q;
  assign overflow_err = overflow_q;
  assign framing_err  = framing_q;

endmodule

// File: tb/tb_router_input_buffer.sv
// Directed self-checking bench for router_input_buffer.
module tb_router_input_buffer;
  import router_pkg::*;

  logic        clk, rst_n;
  logic        in_valid;
  logic [31:0] in_flit;
  logic [1:0]  in_type;
  logic        credit_out, route_req, route_gnt;
  logic [3:0]  route_dest;
  logic        out_valid, out_ready;
  logic [31:0] out_flit;
  logic [1:0]  out_type;
  logic [2:0]  occupancy;
  logic        overflow_err, framing_err;

  router_input_buffer #(
    .FLIT_W   (32),
    .DEPTH    (4),
    .DEST_W   (4),
    .DEST_LSB (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_flit      (in_flit),
    .in_type      (in_type),
    .credit_out   (credit_out),
    .route_req    (route_req),
    .route_dest   (route_dest),
    .route_gnt    (route_gnt),
    .out_valid    (out_valid),
    .out_flit     (out_flit),
    .out_type     (out_type),
    .out_ready    (out_ready),
    .occupancy    (occupancy),
    .overflow_err (overflow_err),
    .framing_err  (framing_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          credit_cnt, req_cnt;
  logic [33:0] got_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Records the handshake the coming edge will see, then advances to the
  // next falling edge and tallies credit pulses and route requests.
  task automatic tick();
    if (out_valid && out_ready) got_q.push_back({out_type, out_flit});
    @(negedge clk);
    if (credit_out) credit_cnt++;
    if (route_req) req_cnt++;
  endtask

  task automatic push(input logic [31:0] f, input logic [1:0] t);
    in_valid = 1'b1;
    in_flit  = f;
    in_type  = t;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc && got_q.size() < n; i++) tick();
    check_eq(tag, 64'(got_q.size()), 64'(n));
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    route_gnt = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    got_q.delete();
    credit_cnt = 0;
    req_cnt    = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_flit   = '0;
    in_type   = '0;
    route_gnt = 1'b0;
    out_ready = 1'b0;
    credit_cnt = 0;
    req_cnt    = 0;
    tick();
    check_eq("rst_credit", credit_out, 0);
    check_eq("rst_req", route_req, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_ovf", overflow_err, 0);
    check_eq("rst_frm", framing_err, 0);
    check_eq("rst_dest", route_dest, 0);
    check_eq("rst_flit", out_flit, 0);
    check_eq("rst_type", out_type, 0);

    // Single packet head(dest=5)/body/tail, grant one cycle after request.
    apply_reset();
    out_ready = 1'b1;
    push(32'hA000_0005, FLIT_HEAD);
    check_eq("t1_req_early", route_req, 0);
    push(32'h1111_1111, FLIT_BODY);
    check_eq("t1_req", route_req, 1);
    check_eq("t1_dest", route_dest, 5);
    check_eq("t1_occ2", occupancy, 2);
    push(32'h2222_2222, FLIT_TAIL);
    check_eq("t1_req_hold", route_req, 1);
    check_eq("t1_valid_pre", out_valid, 0);
    route_gnt = 1'b1;
    tick();
    route_gnt = 1'b0;
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_req_drop", route_req, 0);
    drain(3, 10, "t1_cnt");
    check_eq("t1_f0", got_q[0], {FLIT_HEAD, 32'hA000_0005});
    check_eq("t1_f1", got_q[1], {FLIT_BODY, 32'h1111_1111});
    check_eq("t1_f2", got_q[2], {FLIT_TAIL, 32'h2222_2222});
    tick();
    tick();
    tick();
    check_eq("t1_occ_end", occupancy, 0);
    check_eq("t1_idle", {route_req, out_valid}, 0);
    check_eq("t1_credits", credit_cnt, 3);

    // Single-flit packet, grant held off so the request lasts three cycles.
    apply_reset();
    out_ready = 1'b1;
    push(32'h0000_00A9, FLIT_SINGLE);
    tick();
    check_eq("t2_req", route_req, 1);
    check_eq("t2_dest", route_dest, 9);
    tick();
    tick();
    route_gnt = 1'b1;
    tick();
    route_gnt = 1'b0;
    check_eq("t2_req_drop", route_req, 0);
    check_eq("t2_valid", out_valid, 1);
    drain(1, 10, "t2_cnt");
    check_eq("t2_f0", got_q[0], {FLIT_SINGLE, 32'h0000_00A9});
    tick();
    tick();
    check_eq("t2_req_cycles", req_cnt, 3);
    check_eq("t2_credits", credit_cnt, 1);
    check_eq("t2_idle", {route_req, out_valid, occupancy}, 0);

    // Fill the FIFO with no drain, then a fifth flit overflows.
    apply_reset();
    push(32'h0000_0033, FLIT_HEAD);
    push(32'hB000_0001, FLIT_BODY);
    push(32'hB000_0002, FLIT_BODY);
    push(32'hB000_0003, FLIT_BODY);
    check_eq("t3_occ4", occupancy, 4);
    check_eq("t3_ovf0", overflow_err, 0);
    check_eq("t3_dest", route_dest, 3);
    push(32'hB000_0004, FLIT_BODY);
    check_eq("t3_ovf1", overflow_err, 1);
    check_eq("t3_occ_full", occupancy, 4);
    route_gnt = 1'b1;
    tick();
    route_gnt = 1'b0;
    out_ready = 1'b1;
    drain(4, 12, "t3_cnt");
    check_eq("t3_f0", got_q[0], {FLIT_HEAD, 32'h0000_0033});
    check_eq("t3_f3", got_q[3], {FLIT_BODY, 32'hB000_0003});
    tick();
    tick();
    check_eq("t3_no_fifth", out_valid, 0);
    check_eq("t3_occ_end", occupancy, 0);

    // Full FIFO with simultaneous push and pop.
    apply_reset();
    route_gnt = 1'b1;
    push(32'h0000_0006, FLIT_HEAD);
    push(32'hC000_0001, FLIT_BODY);
    push(32'hC000_0002, FLIT_BODY);
    push(32'hC000_0003, FLIT_BODY);
    check_eq("t4_occ_full", occupancy, 4);
    check_eq("t4_valid", out_valid, 1);
    out_ready = 1'b1;
    push(32'hC000_00FF, FLIT_TAIL);
    out_ready = 1'b0;
    check_eq("t4_occ_same", occupancy, 4);
    check_eq("t4_ovf", overflow_err, 0);
    check_eq("t4_credit", credit_out, 1);
    check_eq("t4_front", out_flit, 32'hC000_0001);
    out_ready = 1'b1;
    drain(5, 12, "t4_cnt");
    check_eq("t4_f1", got_q[1], {FLIT_BODY, 32'hC000_0001});
    check_eq("t4_f3", got_q[3], {FLIT_BODY, 32'hC000_0003});
    check_eq("t4_f4", got_q[4], {FLIT_TAIL, 32'hC000_00FF});
    tick();
    tick();
    check_eq("t4_occ_end", occupancy, 0);
    check_eq("t4_credits", credit_cnt, 5);

    // Stray body flit right after reset.
    apply_reset();
    push(32'h0000_DEAD, FLIT_BODY);
    tick();
    check_eq("t5_frm", framing_err, 1);
    check_eq("t5_occ", occupancy, 0);
    check_eq("t5_credit", credit_out, 1);
    tick();
    check_eq("t5_credit_off", credit_out, 0);
    tick();
    tick();
    check_eq("t5_credits", credit_cnt, 1);
    check_eq("t5_no_req", req_cnt, 0);
    check_eq("t5_no_valid", out_valid, 0);

    // Asynchronous reset mid-packet, then a clean packet.
    apply_reset();
    push(32'h0000_0044, FLIT_HEAD);
    push(32'hD000_0001, FLIT_BODY);
    push(32'hD000_0002, FLIT_BODY);
    check_eq("t6_occ3", occupancy, 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_occ", occupancy, 0);
    check_eq("t6_rst_req", route_req, 0);
    check_eq("t6_rst_valid", out_valid, 0);
    check_eq("t6_rst_front", {out_type, out_flit, route_dest}, 0);
    check_eq("t6_rst_credit", credit_out, 0);
    tick();
    rst_n = 1'b1;
    got_q.delete();
    credit_cnt = 0;
    req_cnt    = 0;
    route_gnt  = 1'b1;
    out_ready  = 1'b1;
    push(32'h0000_0057, FLIT_SINGLE);
    drain(1, 10, "t6_cnt");
    check_eq("t6_f0", got_q[0], {FLIT_SINGLE, 32'h0000_0057});
    tick();
    tick();
    check_eq("t6_credits", credit_cnt, 1);
    check_eq("t6_occ_end", occupancy, 0);
    check_eq("t6_frm", framing_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
